// File: rtl/pc_seq.sv
// pc_seq: sequencing program counter feeding the program-store/decoder.
// Supports increment, absolute and carry-conditional jumps, call/return via a
// small LIFO of return addresses, and halt/resume. Illegal stack use (call on a
// full stack, return on an empty one) parks the sequencer in FAULT until reset.
module pc_seq #(
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic                           en,
  input  logic [2:0]                     op,
  input  logic                           cy,
  input  logic [ADDR_W-1:0]              target,
  input  logic                           resume,
  output logic [ADDR_W-1:0]              addr,
  output logic                           halted,
  output logic                           fault,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           stack_ovf,
  output logic                           stack_unf
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = PTR_W + 1;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
  localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JC   = 3'b010;
  localparam logic [2:0] OP_JNC  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];

  logic                pushEn;
  logic [ADDR_W-1:0]   addrInc;
  logic [PTR_W-1:0]    pushIdx;
  logic [PTR_W-1:0]    topIdx;

  // Sequential address (wraps modulo 2^ADDR_W) doubles as the return address
  assign addrInc = addr_q + ADDR_ONE;
  // Next free slot is at sp; the top entry sits one below (sp==DEPTH wraps to DEPTH-1)
  assign pushIdx = sp_q[PTR_W-1:0];
  assign topIdx  = sp_q[PTR_W-1:0] - PTR_ONE;

  // Next-state decode: stall holds everything, FAULT is terminal until reset
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    pushEn  = 1'b0;
    if (en) begin
      case (state_q)
        ST_RUN: begin
          case (op)
            OP_JMP:  addr_d = target;
            OP_JC:   addr_d = cy ? target : addrInc;
            OP_JNC:  addr_d = cy ? addrInc : target;
            OP_CALL: begin
              if (sp_q != SP_FULL) begin
                pushEn = 1'b1;
                sp_d   = sp_q + SP_ONE;
                addr_d = target;
              end else begin
                ovf_d   = 1'b1;
                state_d = ST_FAULT;
              end
            end
            OP_RET: begin
              if (sp_q != '0) begin
                addr_d = stack_q[topIdx];
                sp_d   = sp_q - SP_ONE;
              end else begin
                unf_d   = 1'b1;
                state_d = ST_FAULT;
              end
            end
            OP_HALT: state_d = ST_HALT;
            default: addr_d = addrInc;
          endcase
        end
        ST_HALT: begin
          if (resume) begin
            addr_d  = addrInc;
            state_d = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, address, stack pointer, sticky flags and return stack registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_RUN;
      addr_q  <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (pushEn) begin
        stack_q[pushIdx] <= addrInc;
      end
    end
  end

  assign addr      = addr_q;
  assign halted    = (state_q == ST_HALT);
  assign fault     = (state_q == ST_FAULT);
  assign sp        = sp_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed, table-driven self-checking bench for pc_seq.
module tb_pc_seq;

  logic       clk;
  logic       nReset;
  logic       en;
  logic [2:0] op;
  logic       cy;
  logic [4:0] target;
  logic       resume;
  logic [4:0] addr;
  logic       halted;
  logic       fault;
  logic [2:0] sp;
  logic       stack_ovf;
  logic       stack_unf;

  int compared;
  int mismatched;

  localparam logic [2:0] INC  = 3'b000;
  localparam logic [2:0] JMP  = 3'b001;
  localparam logic [2:0] JC   = 3'b010;
  localparam logic [2:0] JNC  = 3'b011;
  localparam logic [2:0] CALL = 3'b100;
  localparam logic [2:0] RET  = 3'b101;
  localparam logic [2:0] HLT  = 3'b110;
  localparam logic [2:0] RSV  = 3'b111;

  typedef struct {
    logic       en;
    logic [2:0] op;
    logic       cy;
    logic [4:0] target;
    logic       resume;
    logic [4:0] expAddr;
    logic       expHalted;
    logic       expFault;
    logic [2:0] expSp;
    logic       expOvf;
    logic       expUnf;
  } vec_t;

  vec_t vecs[$];

  pc_seq #(.ADDR_W(5), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .en        (en),
    .op        (op),
    .cy        (cy),
    .target    (target),
    .resume    (resume),
    .addr      (addr),
    .halted    (halted),
    .fault     (fault),
    .sp        (sp),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still terminates
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  function automatic void addVec(input logic e, input logic [2:0] o, input logic c,
                                 input logic [4:0] t, input logic r, input logic [4:0] a,
                                 input logic h, input logic f, input logic [2:0] s,
                                 input logic ov, input logic un);
    vec_t v;
    v.en = e; v.op = o; v.cy = c; v.target = t; v.resume = r;
    v.expAddr = a; v.expHalted = h; v.expFault = f; v.expSp = s;
    v.expOvf = ov; v.expUnf = un;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, let one rising edge pass, sample 1 unit later
  task automatic applyStimulus(input logic e, input logic [2:0] o, input logic c,
                               input logic [4:0] t, input logic r);
    en = e; op = o; cy = c; target = t; resume = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] a, input logic h,
                             input logic f, input logic [2:0] s, input logic ov,
                             input logic un);
    compared++;
    if (addr !== a || halted !== h || fault !== f || sp !== s ||
        stack_ovf !== ov || stack_unf !== un) begin
      mismatched++;
      $display("[TB] FAIL %s: got addr=%0d halted=%b fault=%b sp=%0d ovf=%b unf=%b, want addr=%0d halted=%b fault=%b sp=%0d ovf=%b unf=%b",
               tag, addr, halted, fault, sp, stack_ovf, stack_unf, a, h, f, s, ov, un);
    end
  endtask

  task automatic doReset();
    nReset = 1'b0;
    en = 1'b0; op = INC; cy = 1'b0; target = '0; resume = 1'b0;
    #3;
    checkOutput("reset_hold", 5'd0, 0, 0, 3'd0, 0, 0);
    @(posedge clk);
    #2;
    nReset = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    nReset = 1'b1;
    en = 1'b0; op = INC; cy = 1'b0; target = '0; resume = 1'b0;
    #2;

    // Table: jumps, conditional jumps, call/return incl. wrap push, halt/resume
    addVec(1, JMP,  0, 5'd3,  0, 5'd3,  0, 0, 3'd0, 0, 0);
    addVec(1, JC,   0, 5'd20, 0, 5'd4,  0, 0, 3'd0, 0, 0);
    addVec(1, JC,   1, 5'd20, 0, 5'd20, 0, 0, 3'd0, 0, 0);
    addVec(1, JNC,  1, 5'd9,  0, 5'd21, 0, 0, 3'd0, 0, 0);
    addVec(1, JNC,  0, 5'd5,  0, 5'd5,  0, 0, 3'd0, 0, 0);
    addVec(1, CALL, 0, 5'd10, 0, 5'd10, 0, 0, 3'd1, 0, 0);
    addVec(1, CALL, 0, 5'd31, 0, 5'd31, 0, 0, 3'd2, 0, 0);
    addVec(0, JMP,  0, 5'd2,  1, 5'd31, 0, 0, 3'd2, 0, 0);
    addVec(1, CALL, 0, 5'd31, 0, 5'd31, 0, 0, 3'd3, 0, 0);
    addVec(1, RET,  0, 5'd0,  0, 5'd0,  0, 0, 3'd2, 0, 0);
    addVec(1, RET,  0, 5'd0,  0, 5'd11, 0, 0, 3'd1, 0, 0);
    addVec(1, RET,  0, 5'd0,  0, 5'd6,  0, 0, 3'd0, 0, 0);
    addVec(1, RSV,  0, 5'd0,  0, 5'd7,  0, 0, 3'd0, 0, 0);
    addVec(1, INC,  0, 5'd0,  0, 5'd8,  0, 0, 3'd0, 0, 0);
    addVec(1, INC,  0, 5'd0,  0, 5'd9,  0, 0, 3'd0, 0, 0);
    addVec(1, HLT,  0, 5'd0,  1, 5'd9,  1, 0, 3'd0, 0, 0);
    addVec(1, JMP,  0, 5'd2,  0, 5'd9,  1, 0, 3'd0, 0, 0);
    addVec(0, INC,  0, 5'd0,  1, 5'd9,  1, 0, 3'd0, 0, 0);
    addVec(1, JMP,  0, 5'd2,  1, 5'd10, 0, 0, 3'd0, 0, 0);
    addVec(1, INC,  0, 5'd0,  1, 5'd11, 0, 0, 3'd0, 0, 0);

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].op, vecs[i].cy, vecs[i].target, vecs[i].resume);
      checkOutput($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expHalted,
                  vecs[i].expFault, vecs[i].expSp, vecs[i].expOvf, vecs[i].expUnf);
    end

    // 33 increments from reset: 1..31, wrap to 0, then 1
    doReset();
    for (int k = 1; k <= 33; k++) begin
      applyStimulus(1, INC, 0, 5'd0, 0);
      checkOutput($sformatf("inc%0d", k), 5'(k % 32), 0, 0, 3'd0, 0, 0);
    end

    // Halt hold: five cycles with resume low, then en-gated resume, then resume
    doReset();
    applyStimulus(1, JMP, 0, 5'd9, 0);
    applyStimulus(1, HLT, 0, 5'd0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, INC, 0, 5'd0, 0);
      checkOutput($sformatf("halt_hold%0d", k), 5'd9, 1, 0, 3'd0, 0, 0);
    end
    applyStimulus(0, INC, 0, 5'd0, 1);
    checkOutput("halt_en0", 5'd9, 1, 0, 3'd0, 0, 0);
    applyStimulus(1, INC, 0, 5'd0, 1);
    checkOutput("halt_resume", 5'd10, 0, 0, 3'd0, 0, 0);

    // Stack overflow: four nested calls fill the stack, the fifth faults
    doReset();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, CALL, 0, 5'(k), 0);
      checkOutput($sformatf("nest%0d", k), 5'(k), 0, 0, 3'(k), 0, 0);
    end
    applyStimulus(1, CALL, 0, 5'd20, 0);
    checkOutput("ovf", 5'd4, 0, 1, 3'd4, 1, 0);
    applyStimulus(1, RET, 0, 5'd0, 1);
    checkOutput("ovf_ret_ignored", 5'd4, 0, 1, 3'd4, 1, 0);
    applyStimulus(1, JMP, 1, 5'd17, 1);
    checkOutput("ovf_jmp_ignored", 5'd4, 0, 1, 3'd4, 1, 0);
    // Asynchronous reset takes effect between edges
    nReset = 1'b0;
    #1;
    checkOutput("ovf_async_reset", 5'd0, 0, 0, 3'd0, 0, 0);
    #1;
    nReset = 1'b1;
    applyStimulus(1, RET, 0, 5'd0, 0);
    checkOutput("after_reset_ret_empty", 5'd0, 0, 1, 3'd0, 0, 1);

    // Stack underflow at addr 7
    doReset();
    applyStimulus(1, JMP, 0, 5'd7, 0);
    applyStimulus(1, RET, 0, 5'd0, 0);
    checkOutput("unf", 5'd7, 0, 1, 3'd0, 0, 1);
    applyStimulus(1, INC, 0, 5'd0, 1);
    checkOutput("unf_hold", 5'd7, 0, 1, 3'd0, 0, 1);

    // Call from all-ones pushes the wrapped return address 0
    doReset();
    applyStimulus(1, JMP, 0, 5'd31, 0);
    applyStimulus(1, CALL, 0, 5'd12, 0);
    checkOutput("call_wrap", 5'd12, 0, 0, 3'd1, 0, 0);
    applyStimulus(1, RET, 0, 5'd0, 0);
    checkOutput("ret_wrap", 5'd0, 0, 0, 3'd0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
